// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache feeding IF.
// A miss refills the line byte-serially over the shared 8-bit memory bus.
module icache #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_ok,
    output logic [31:0] inst_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                 r_state, w_next;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [31:0]            r_data [LINES];

    logic [31:0]            r_fill_pc;
    logic [2:0]             r_issue_cnt;
    logic [2:0]             r_recv_cnt;
    logic                   r_pend;
    logic [23:0]            r_word;

    logic [INDEX_BITS-1:0]  w_idx, w_fill_idx;
    logic [TAG_W-1:0]       w_tag, w_fill_tag;
    logic                   w_hit, w_issue, w_done;
    logic [31:0]            w_word, w_fill_base;

    assign w_idx       = pc[INDEX_BITS+1:2];
    assign w_tag       = pc[31:INDEX_BITS+2];
    assign w_fill_idx  = r_fill_pc[INDEX_BITS+1:2];
    assign w_fill_tag  = r_fill_pc[31:INDEX_BITS+2];
    assign w_fill_base = {r_fill_pc[31:2], 2'b00};
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign mem_req  = (r_state == S_FILL) && (r_issue_cnt != 3'd4);
    assign mem_addr = mem_req ? (w_fill_base + {29'd0, r_issue_cnt}) : '0;
    assign w_issue  = mem_req && mem_grant;
    // The 4th byte is on mem_din right now, so the word is completed combinationally
    assign w_done   = (r_state == S_FILL) && r_pend && (r_recv_cnt == 3'd3);
    assign w_word   = {mem_din, r_word};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_hit) w_next = S_FILL;
            S_FILL:  if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            inst_ok     <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            r_fill_pc   <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_pend      <= 1'b0;
            r_word      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    inst_ok <= w_hit;
                    if (w_hit) begin
                        inst    <= r_data[w_idx];
                        inst_pc <= pc;
                    end else begin
                        r_fill_pc   <= pc;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_pend      <= 1'b0;
                    end
                end
                S_FILL: begin
                    inst_ok <= w_done;
                    r_pend  <= w_issue;
                    if (w_issue) r_issue_cnt <= r_issue_cnt + 3'd1;
                    if (r_pend) begin
                        r_recv_cnt <= r_recv_cnt + 3'd1;
                        case (r_recv_cnt)
                            3'd0:    r_word[7:0]   <= mem_din;
                            3'd1:    r_word[15:8]  <= mem_din;
                            3'd2:    r_word[23:16] <= mem_din;
                            default: ;
                        endcase
                    end
                    if (w_done) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        inst                <= w_word;
                        inst_pc             <= r_fill_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_done && !rst) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= w_word;
        end
    end
endmodule
